// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle for imem_fetch_ctrl.
// Carries the instruction-memory read port and the valid/ready instruction
// stream toward decode.
//   master : the fetch controller (drives address and the instruction stream)
//   slave  : memory + decode side (returns read data, drives instr_ready)
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for the 64-word instruction memory.
// Owns the PC, drives the memory byte address from the PC register, pushes
// fetched {word, pc} pairs into a small FIFO that feeds decode through a
// valid/ready handshake, and handles start/halt, end-of-program and redirects.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           pulse, IDLE/HALT -> RUN
//   halt_req        pulse, RUN -> HALT (no fetch that cycle)
//   redirect_valid  load redirect_pc (word aligned) and flush the buffer
//   redirect_pc     redirect target
//   bus             imem_fetch_ctrl_if master: imem_addr/imem_rdata,
//                   instr_valid/instr_ready/instr/instr_pc
//   busy, halted    state == RUN / state == HALT
//   fetch_count     saturating count of pushed instructions
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | after reset; no fetching, waiting for start
// S_RUN  | fetching one word per cycle while the buffer has room
// S_HALT | halted by halt_req or end of program; buffer still drains
module imem_fetch_ctrl #(
    parameter int                ADDR_W  = 8,
    parameter int                DEPTH   = 2,
    parameter logic [ADDR_W-1:0] LAST_PC = 8'h4C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    imem_fetch_ctrl_if.master  bus,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       buf_instr [DEPTH];
    logic [ADDR_W-1:0] buf_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              pop;
    logic              fetch;

    assign empty = (count == '0);
    assign pop   = !empty && bus.instr_ready;

    // A pop in the same cycle frees a slot, so a full buffer can still fetch.
    assign fetch = (state_q == S_RUN) && !redirect_valid && !halt_req &&
                   ((count < DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect leaves the state alone; in IDLE/HALT it only moves the resume PC.
    always_comb begin
        state_d = state_q;
        if (!redirect_valid) begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (fetch && (pc_q == LAST_PC)) begin
                        state_d = S_HALT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any pop in the same cycle.
            pc_q   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                pc_q   <= pc_q + ADDR_W'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (fetch_count != 16'hFFFF) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= pc_q;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = empty ? '0 : buf_instr[rd_ptr];
    assign bus.instr_pc    = empty ? '0 : buf_pc[rd_ptr];

    assign busy   = (state_q == S_RUN);
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       busy;
    logic       halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    int checks;
    int passes;

    imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W (8),
        .DEPTH  (2),
        .LAST_PC(8'h4C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt_req      (halt_req),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus),
        .busy          (busy),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        bus.instr_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_imem_addr got=%h exp=00", bus.imem_addr); else passes++;
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid); else passes++;
        checks++; if (bus.instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", bus.instr); else passes++;
        checks++; if (bus.instr_pc !== 8'h00) $display("FAIL reset_instr_pc got=%h exp=00", bus.instr_pc); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passes++;
        checks++; if (fetch_count !== 16'd0) $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); else passes++;
    endtask

    task automatic test_full_run();
        apply_reset();
        bus.instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", busy); else passes++;
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL run_first_valid got=%b exp=0", bus.instr_valid); else passes++;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++; if (bus.instr_valid !== 1'b1) $display("FAIL run_valid[%0d] got=%b exp=1", k, bus.instr_valid); else passes++;
            checks++; if (bus.instr !== mem[k]) $display("FAIL run_instr[%0d] got=%h exp=%h", k, bus.instr, mem[k]); else passes++;
            checks++; if (bus.instr_pc !== 8'(k * 4)) $display("FAIL run_instr_pc[%0d] got=%h exp=%h", k, bus.instr_pc, 8'(k * 4)); else passes++;
            if (k == 18) begin
                checks++; if (halted !== 1'b0) $display("FAIL run_early_halt got=%b exp=0", halted); else passes++;
            end
        end
        checks++; if (bus.instr !== 32'h03002603) $display("FAIL run_last_instr got=%h exp=03002603", bus.instr); else passes++;
        checks++; if (halted !== 1'b1) $display("FAIL run_halted got=%b exp=1", halted); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL run_busy_end got=%b exp=0", busy); else passes++;
        checks++; if (bus.imem_addr !== 8'h50) $display("FAIL run_end_pc got=%h exp=50", bus.imem_addr); else passes++;
        checks++; if (fetch_count !== 16'd20) $display("FAIL run_fetch_count got=%0d exp=20", fetch_count); else passes++;
        step();
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL run_drained got=%b exp=0", bus.instr_valid); else passes++;
        checks++; if (fetch_count !== 16'd20) $display("FAIL run_fetch_count_hold got=%0d exp=20", fetch_count); else passes++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++; if (bus.instr_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", bus.instr_valid); else passes++;
        checks++; if (bus.instr !== 32'h00007033) $display("FAIL bp_head got=%h exp=00007033", bus.instr); else passes++;
        checks++; if (bus.instr_pc !== 8'h00) $display("FAIL bp_head_pc got=%h exp=00", bus.instr_pc); else passes++;
        checks++; if (bus.imem_addr !== 8'h08) $display("FAIL bp_pc_hold got=%h exp=08", bus.imem_addr); else passes++;
        checks++; if (fetch_count !== 16'd2) $display("FAIL bp_fetch_count got=%0d exp=2", fetch_count); else passes++;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (bus.instr !== mem[k]) $display("FAIL bp_deliver[%0d] got=%h exp=%h", k, bus.instr, mem[k]); else passes++;
            checks++; if (bus.instr_pc !== 8'(k * 4)) $display("FAIL bp_deliver_pc[%0d] got=%h exp=%h", k, bus.instr_pc, 8'(k * 4)); else passes++;
            checks++; if (bus.imem_addr !== 8'(8 + k * 4)) $display("FAIL bp_addr[%0d] got=%h exp=%h", k, bus.imem_addr, 8'(8 + k * 4)); else passes++;
            step();
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_redirect();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++; if (bus.imem_addr !== 8'h08) $display("FAIL rd_pre_pc got=%h exp=08", bus.imem_addr); else passes++;
        bus.instr_ready = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 8'h22;
        step();
        redirect_valid  = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rd_flush got=%b exp=0", bus.instr_valid); else passes++;
        checks++; if (bus.imem_addr !== 8'h20) $display("FAIL rd_target got=%h exp=20", bus.imem_addr); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL rd_busy got=%b exp=1", busy); else passes++;
        checks++; if (fetch_count !== 16'd2) $display("FAIL rd_no_fetch got=%0d exp=2", fetch_count); else passes++;
        step();
        checks++; if (bus.instr !== 32'h00218433) $display("FAIL rd_first_instr got=%h exp=00218433", bus.instr); else passes++;
        checks++; if (bus.instr_pc !== 8'h20) $display("FAIL rd_first_pc got=%h exp=20", bus.instr_pc); else passes++;
        step();
        checks++; if (bus.instr !== mem[9]) $display("FAIL rd_second_instr got=%h exp=%h", bus.instr, mem[9]); else passes++;
        checks++; if (bus.instr_pc !== 8'h24) $display("FAIL rd_second_pc got=%h exp=24", bus.instr_pc); else passes++;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        halt_req = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL halt_busy got=%b exp=0", busy); else passes++;
        checks++; if (halted !== 1'b1) $display("FAIL halt_halted got=%b exp=1", halted); else passes++;
        checks++; if (bus.imem_addr !== 8'h08) $display("FAIL halt_no_fetch got=%h exp=08", bus.imem_addr); else passes++;
        checks++; if (bus.instr !== mem[1]) $display("FAIL halt_drain1 got=%h exp=%h", bus.instr, mem[1]); else passes++;
        checks++; if (bus.instr_pc !== 8'h04) $display("FAIL halt_drain1_pc got=%h exp=04", bus.instr_pc); else passes++;
        step();
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL halt_drained got=%b exp=0", bus.instr_valid); else passes++;
        checks++; if (fetch_count !== 16'd2) $display("FAIL halt_fetch_count got=%0d exp=2", fetch_count); else passes++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL resume_busy got=%b exp=1", busy); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL resume_halted got=%b exp=0", halted); else passes++;
        checks++; if (bus.imem_addr !== 8'h08) $display("FAIL resume_pc got=%h exp=08", bus.imem_addr); else passes++;
        step();
        checks++; if (bus.instr !== mem[2]) $display("FAIL resume_instr got=%h exp=%h", bus.instr, mem[2]); else passes++;
        checks++; if (bus.instr_pc !== 8'h08) $display("FAIL resume_instr_pc got=%h exp=08", bus.instr_pc); else passes++;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [3];
        logic [31:0] exp_ins [3];
        exp_pc[0] = 8'hFC; exp_pc[1] = 8'h00; exp_pc[2] = 8'h04;
        exp_ins[0] = 32'hA000003F; exp_ins[1] = 32'h00007033; exp_ins[2] = 32'h00300093;
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 8'hFC) $display("FAIL wrap_idle_redirect got=%h exp=FC", bus.imem_addr); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL wrap_idle_busy got=%b exp=0", busy); else passes++;
        bus.instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.instr_pc !== exp_pc[k]) $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, bus.instr_pc, exp_pc[k]); else passes++;
            checks++; if (bus.instr !== exp_ins[k]) $display("FAIL wrap_instr[%0d] got=%h exp=%h", k, bus.instr, exp_ins[k]); else passes++;
        end
        checks++; if (bus.imem_addr !== 8'h08) $display("FAIL wrap_next_pc got=%h exp=08", bus.imem_addr); else passes++;
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++; if (bus.instr_valid !== 1'b1) $display("FAIL mr_pre_valid got=%b exp=1", bus.instr_valid); else passes++;
        rst             = 1'b1;
        start           = 1'b1;
        halt_req        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 8'h40;
        bus.instr_ready = 1'b1;
        step();
        checks++; if (bus.imem_addr !== 8'h00) $display("FAIL mr_imem_addr got=%h exp=00", bus.imem_addr); else passes++;
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL mr_instr_valid got=%b exp=0", bus.instr_valid); else passes++;
        checks++; if (bus.instr !== 32'h0) $display("FAIL mr_instr got=%h exp=0", bus.instr); else passes++;
        checks++; if (bus.instr_pc !== 8'h00) $display("FAIL mr_instr_pc got=%h exp=00", bus.instr_pc); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mr_busy got=%b exp=0", busy); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL mr_halted got=%b exp=0", halted); else passes++;
        checks++; if (fetch_count !== 16'd0) $display("FAIL mr_fetch_count got=%0d exp=0", fetch_count); else passes++;
        rst            = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL mr_idle_busy got=%b exp=0", busy); else passes++;
        checks++; if (bus.imem_addr !== 8'h00) $display("FAIL mr_idle_pc got=%h exp=00", bus.imem_addr); else passes++;
        checks++; if (bus.instr_valid !== 1'b0) $display("FAIL mr_idle_valid got=%b exp=0", bus.instr_valid); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA0000000 | 32'(i);
        mem[0]  = 32'h00007033; mem[1]  = 32'h00300093; mem[2]  = 32'h00500113;
        mem[3]  = 32'h00A00193; mem[4]  = 32'h00B00213; mem[5]  = 32'h00C00293;
        mem[6]  = 32'h00D00313; mem[7]  = 32'h00E00393; mem[8]  = 32'h00218433;
        mem[9]  = 32'h004284B3; mem[10] = 32'h00630533; mem[11] = 32'h008385B3;
        mem[12] = 32'h40A48633; mem[13] = 32'h00C5F6B3; mem[14] = 32'h00D6E733;
        mem[15] = 32'h00E747B3; mem[16] = 32'h00F02023; mem[17] = 32'h00102223;
        mem[18] = 32'h00202423; mem[19] = 32'h03002603;

        test_reset();
        test_full_run();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_midrun();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the 64-word instruction memory. It owns the program counter and drives the memory's byte address every cycle. Fetched words go into a 2-entry buffer, which presents them to decode with a valid/ready handshake. The block also handles start, halt, end-of-program detection and PC redirects (branch/jump), and sits between the instruction memory and the decode stage of the core.

## Interface
- ADDR_W, 8, byte-address / PC width (matches memory address port)
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- LAST_PC, 8'h4C, byte address of the final program instruction (word 19); fetching it ends the run
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; IDLE/HALT → RUN
- halt_req  in  1  pulse; RUN → HALT, no fetch that cycle
- redirect_valid  in  1  load new PC and flush buffer
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0
- imem_addr  out  ADDR_W  byte address to instruction memory (= pc register)
- imem_rdata  in  32  combinational read data for imem_addr
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  buffer head instruction; 0 when empty
- instr_pc  out  ADDR_W  PC of buffer head; 0 when empty
- busy  out  1  state == RUN
- halted  out  1  state == HALT
- fetch_count  out  16  instructions pushed since reset, saturates at 16'hFFFF

## Operation
- States: IDLE (after reset), RUN, HALT.
- IDLE/HALT + start → RUN. RUN + halt_req → HALT, which wins over start in the same cycle.
- RUN + fetch of pc == LAST_PC → HALT next cycle.
- start in RUN is ignored.
- Fetch condition, evaluated in RUN only: !redirect_valid && !halt_req && (count < DEPTH || pop).
- pop = instr_valid && instr_ready.
- On fetch:
  - push {imem_rdata, pc} at the buffer tail.
  - pc ← pc + 4, modulo 2^ADDR_W; 8'hFC wraps to 8'h00.
  - fetch_count++ unless saturated.
- Buffer is a FIFO: push and pop can occur in the same cycle when full, and count is unchanged.
- Redirect has highest priority in every state:
  - pc ← {redirect_pc[7:2], 2'b00}.
  - Buffer flushed (count ← 0); a simultaneous pop is discarded.
  - No fetch that cycle.
  - State is unchanged. In IDLE/HALT the redirect only sets the resume PC.
- HALT stops new fetches. Entries already buffered still drain to decode normally.
- Resume from HALT continues at the current pc.
- imem_addr is driven combinationally from the pc register only, never from inputs.

## Timing
- Reset values:
  - pc = 0, imem_addr = 0.
  - state = IDLE, count = 0.
  - instr_valid = 0, instr = 0, instr_pc = 0.
  - busy = 0, halted = 0, fetch_count = 0.
- rst asserted mid-run overrides start, halt_req and redirect, and discards all buffered entries.
- start sampled at cycle N:
  - busy = 1 and the first fetch happen at N+1.
  - instr_valid = 1 at N+2 with instr = mem[pc>>2].
- Fetch at cycle N → entry visible on instr/instr_pc at N+1 (registered buffer, no combinational path from imem_rdata to instr).
- Throughput is one instruction per cycle with instr_ready held high.
- With instr_ready low: exactly DEPTH fetches, then fetch stops and pc holds.
  - Fetch resumes in the first cycle instr_ready is high, because pop frees a slot the same cycle.
- Redirect at cycle N:
  - instr_valid = 0 at N+1, imem_addr = target at N+1.
  - Target instruction valid at N+2.
- LAST_PC fetched at N: halted = 1 at N+1, with pc = LAST_PC + 4.
- halt_req at N: busy = 0 and halted = 1 at N+1; no fetch at N.

## Test plan
- Reset, then start with instr_ready = 1:
  - instr sequence must be 0x00007033, 0x00300093, …, 0x03002603 with instr_pc 0x00…0x4C, one per cycle.
  - halted = 1 at the cycle after the 0x4C fetch; fetch_count = 20.
- Backpressure: instr_ready = 0 for 5 cycles after start.
  - Exactly 2 entries are buffered, pc holds at 0x08, and the head stays 0x00007033.
  - After release, delivery is in order with no loss or duplication.
- Redirect to 0x22 while buffer full and instr_ready = 1:
  - Buffer flushed, imem_addr = 0x20 next cycle.
  - Next delivered instr = 0x00218433 (pc 0x20); the popped head is not counted as delivered.
- halt_req during RUN with 2 entries buffered:
  - No further fetches; both entries drain.
  - A later start resumes at the held pc.
- Redirect to 0xFC with LAST_PC = 8'hFF-unreachable:
  - pc wraps 0xFC → 0x00.
  - instr_pc sequence is 0xFC, 0x00, 0x04.
- Reset asserted mid-run with a full buffer:
  - All outputs return to their reset values the next cycle.
  - start, halt_req and redirect applied in the same cycle as rst are ignored.
